// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
//   muldiv_op_t : request opcode as driven by the core's decode
//   state_t     : sequencer FSM states
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MFHI  = 3'b100,
    OP_MFLO  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the unsigned multiply or restoring divide.
//   mode       : 0 = shift-add multiply, 1 = shift-trial-subtract divide
//   acc        : multiply {partial, multiplier}; divide {remainder, quotient}
//   operand    : multiplicand (mul) or divisor (div)
//   acc_next_c : accumulator after this step (combinational)
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh     = acc[2*WIDTH-1:WIDTH-1];
    trial      = rem_sh - {1'b0, operand};
    acc_next_c = acc;
    if (!mode) begin
      // Multiplier LSB selects the add; carry shifts into the top of the partial.
      if (acc[0]) acc_next_c = {sum, acc[WIDTH-1:1]};
      else        acc_next_c = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      // Sign bit of the trial difference decides keep (1) or restore (0).
      if (!trial[WIDTH]) acc_next_c = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next_c = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MF*/MT* access.
//   clk, reset      : clock, synchronous active-low reset
//   req_valid/ready : request handshake; ready is high only while idle
//   req_op          : muldiv_op_t opcode
//   src_a, src_b    : rs / rt operands
//   abort           : cancels an in-flight op, blocks accept when idle
//   hi, lo          : architectural registers
//   done            : pulse when MULT*/DIV* has written hi/lo
//   div_by_zero     : with done, divisor was zero
//   rd_valid/rd_data: MFHI/MFLO result pulse and data
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_step_c;
  logic [AW-1:0]    fixed_c;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;
  logic             fix_ph;

  muldiv_op_t       op_c;
  logic             accept_c;
  logic             start_mul_c;
  logic             start_div_c;
  logic             signed_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode       (is_div),
    .acc        (acc),
    .operand    (opnd),
    .acc_next_c (acc_step_c)
  );

  // Request decode and next-state logic.
  always_comb begin
    state_d     = state;
    op_c        = muldiv_op_t'(req_op);
    accept_c    = req_valid & req_ready & ~abort;
    start_mul_c = accept_c & ((op_c == OP_MULT) | (op_c == OP_MULTU));
    start_div_c = accept_c & ((op_c == OP_DIV)  | (op_c == OP_DIVU));
    unique case (state)
      IDLE: begin
        if (start_mul_c)      state_d = MUL;
        else if (start_div_c) state_d = DIV;
      end
      MUL, DIV: begin
        if (abort)            state_d = IDLE;
        else if (cnt == '0)   state_d = FIX;
      end
      FIX: begin
        if (abort || fix_ph)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes for the signed ops; the core runs unsigned.
  always_comb begin
    signed_c = (op_c == OP_MULT) | (op_c == OP_DIV);
    abs_a_c  = (signed_c && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b_c  = (signed_c && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Sign correction, registered back into acc during the first FIX cycle.
  always_comb begin
    fixed_c = acc;
    if (!is_div) begin
      if (neg_q) fixed_c = -acc;
    end else if (dbz) begin
      fixed_c = {a_raw, {WIDTH{1'b1}}};
    end else begin
      fixed_c[AW-1:WIDTH]  = neg_r ? -acc[AW-1:WIDTH]  : acc[AW-1:WIDTH];
      fixed_c[WIDTH-1:0]   = neg_q ? -acc[WIDTH-1:0]   : acc[WIDTH-1:0];
    end
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      fix_ph      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      rd_data     <= '0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      req_ready   <= (state_d == IDLE);
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            unique case (op_c)
              OP_MULT, OP_MULTU: begin
                acc    <= {WIDTH'(0), abs_b_c};
                opnd   <= abs_a_c;
                is_div <= 1'b0;
                neg_q  <= signed_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r  <= 1'b0;
                dbz    <= 1'b0;
                cnt    <= CW'(WIDTH - 1);
                fix_ph <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                acc    <= {WIDTH'(0), abs_a_c};
                opnd   <= abs_b_c;
                a_raw  <= src_a;
                is_div <= 1'b1;
                neg_q  <= signed_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r  <= signed_c & src_a[WIDTH-1];
                dbz    <= ~|src_b;
                cnt    <= CW'(WIDTH - 1);
                fix_ph <= 1'b0;
              end
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (!abort) begin
            acc <= acc_step_c;
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!abort) begin
            if (!fix_ph) begin
              acc    <= fixed_c;
              fix_ph <= 1'b1;
            end else begin
              hi          <= acc[AW-1:WIDTH];
              lo          <= acc[WIDTH-1:0];
              done        <= 1'b1;
              div_by_zero <= dbz;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for MULT*/DIV* results
// plus hand-written sequences for MT/MF, abort, MF in the done cycle and reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        abort;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_by_zero;
  logic        rd_valid;
  logic [31:0] rd_data;

  int n_cmp;
  int n_bad;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .abort       (abort),
    .hi          (hi),
    .lo          (lo),
    .done        (done),
    .div_by_zero (div_by_zero),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [2:0] op, input logic [31:0] a);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = 32'h0;
    step_clk();
    req_valid = 1'b0;
  endtask

  // Issue a MULT*/DIV* and wait (bounded) for done; lat is the edge index of done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic ready_low);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    step_clk();
    req_valid = 1'b0;
    lat       = -1;
    ready_low = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      step_clk();
      if (done) begin
        lat = e;
        break;
      end
      if (req_ready) ready_low = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic rlow;
    int   done_e;
    int   rd_e;
    int   pulses;

    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    src_a     = 32'hDEAD_BEEF;
    src_b     = 32'h0;

    vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{"mult_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{"div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{"divu_7d0",    OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{"div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{"multu_x16",   OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[6]  = '{"divu_100d7",  OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[7]  = '{"div_7dm2",    OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{"mult_m1xm1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9]  = '{"div_m5d0",    OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{"mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{"divu_maxd1",  OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    // Reset, with an MTHI held active to show reset wins.
    step_clk();
    step_clk();
    chk("rst_hi",       hi,                 32'h0);
    chk("rst_lo",       lo,                 32'h0);
    chk("rst_rd_data",  rd_data,            32'h0);
    chk("rst_done",     32'(done),          32'h0);
    chk("rst_rd_valid", 32'(rd_valid),      32'h0);
    chk("rst_dbz",      32'(div_by_zero),   32'h0);
    chk("rst_ready",    32'(req_ready),     32'h1);
    req_valid = 1'b0;
    reset     = 1'b1;
    step_clk();

    // MT*/MF* single-cycle ops.
    single(OP_MTHI, 32'h0000_1234);
    chk("mthi_hi",   hi,        32'h0000_1234);
    chk("mthi_done", 32'(done), 32'h0);
    single(OP_MTLO, 32'h0000_ABCD);
    chk("mtlo_lo",   lo,        32'h0000_ABCD);
    single(OP_MFHI, 32'h0);
    chk("mfhi_valid", 32'(rd_valid), 32'h1);
    chk("mfhi_data",  rd_data,       32'h0000_1234);
    step_clk();
    chk("mfhi_pulse", 32'(rd_valid), 32'h0);
    single(OP_MFLO, 32'h0);
    chk("mflo_valid", 32'(rd_valid), 32'h1);
    chk("mflo_data",  rd_data,       32'h0000_ABCD);

    // Table of multiply/divide vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rlow);
      chk({vecs[i].name, "_latency"}, 32'(lat),         32'd34);
      chk({vecs[i].name, "_busy"},    32'(rlow),        32'h1);
      chk({vecs[i].name, "_ready"},   32'(req_ready),   32'h1);
      chk({vecs[i].name, "_hi"},      hi,               vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"},      lo,               vecs[i].exp_lo);
      chk({vecs[i].name, "_dbz"},     32'(div_by_zero), 32'(vecs[i].exp_dbz));
      step_clk();
      chk({vecs[i].name, "_done_pulse"}, 32'(done),     32'h0);
    end

    // Abort mid-multiply leaves hi/lo untouched and raises no done.
    single(OP_MTHI, 32'h0000_1234);
    single(OP_MTLO, 32'h0000_5678);
    req_valid = 1'b1;
    req_op    = OP_MULT;
    src_a     = 32'd2;
    src_b     = 32'd3;
    step_clk();
    req_valid = 1'b0;
    repeat (9) step_clk();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'h1);
    chk("abort_done",  32'(done),      32'h0);
    chk("abort_hi",    hi,             32'h0000_1234);
    chk("abort_lo",    lo,             32'h0000_5678);
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      step_clk();
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'h0);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    src_a     = 32'h0000_9999;
    step_clk();
    abort     = 1'b0;
    req_valid = 1'b0;
    chk("abort_idle_block", hi, 32'h0000_1234);

    // MFLO held while busy is accepted in the done cycle and sees the product.
    req_valid = 1'b1;
    req_op    = OP_MULT;
    src_a     = 32'd6;
    src_b     = 32'd7;
    step_clk();
    req_op    = OP_MFLO;
    done_e    = -1;
    rd_e      = -1;
    for (int e = 1; e <= 60; e++) begin
      step_clk();
      if (done) done_e = e;
      if (rd_valid) begin
        rd_e = e;
        break;
      end
    end
    req_valid = 1'b0;
    chk("mf_done_edge", 32'(done_e), 32'd34);
    chk("mf_rd_edge",   32'(rd_e),   32'd35);
    chk("mf_rd_data",   rd_data,     32'd42);
    chk("mf_hi",        hi,          32'h0);

    // Reset in the middle of a divide, then a fresh multiply.
    req_valid = 1'b1;
    req_op    = OP_DIV;
    src_a     = 32'd100;
    src_b     = 32'd3;
    step_clk();
    req_valid = 1'b0;
    repeat (10) step_clk();
    reset = 1'b0;
    step_clk();
    chk("mid_rst_hi",    hi,             32'h0);
    chk("mid_rst_lo",    lo,             32'h0);
    chk("mid_rst_rd",    rd_data,        32'h0);
    chk("mid_rst_done",  32'(done),      32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    reset = 1'b1;
    run_op(OP_MULTU, 32'd2, 32'd2, lat, rlow);
    chk("post_rst_latency", 32'(lat), 32'd34);
    chk("post_rst_lo",      lo,       32'd4);
    chk("post_rst_hi",      hi,       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
